// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector: handshake-loaded pattern/length/overlap, start/stop hunting,
// match counting against a target. Define SEQ_DETECT_REG_OUT_EN to register the z output.
module seq_detect_ctrl #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             stop,
  input  logic             x,
  input  logic             x_valid,
  output logic             z,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count
);

  typedef enum logic [1:0] {IDLE, ARMED, HUNT, DONE} state_t;

  state_t           state_reg;
  logic [PAT_W-1:0] pattern_reg;
  logic [LEN_W-1:0] len_reg;
  logic             overlap_reg;
  logic [CNT_W-1:0] target_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PAT_W-2:0] hist_reg;
  logic [LEN_W-1:0] fill_reg;

  logic [LEN_W-1:0] len_clamped;
  logic [PAT_W-1:0] len_mask;
  logic [PAT_W-1:0] window;
  logic             fill_full;
  logic             hit;
  logic [CNT_W-1:0] count_inc;
  logic             cfg_take;

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0)
      len_clamped = LEN_W'(1);
    else if (cfg_len > LEN_W'(PAT_W))
      len_clamped = LEN_W'(PAT_W);
  end

  // Only the low len bits of the window take part in the comparison.
  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
    assign len_mask[gi] = (LEN_W'(gi) < len_reg);
  end

  assign window    = {hist_reg, x};
  assign fill_full = (fill_reg >= len_reg - LEN_W'(1));
  assign hit       = (state_reg == HUNT) && x_valid && fill_full &&
                     (((window ^ pattern_reg) & len_mask) == '0);
  assign count_inc = (&count_reg) ? count_reg : count_reg + CNT_W'(1);

  assign cfg_ready   = (state_reg == IDLE) || (state_reg == ARMED);
  assign cfg_take    = cfg_valid && cfg_ready;
  assign busy        = (state_reg == HUNT);
  assign done        = (state_reg == DONE);
  assign match_count = count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      pattern_reg <= '0;
      len_reg     <= LEN_W'(1);
      overlap_reg <= 1'b0;
      target_reg  <= '0;
      count_reg   <= '0;
      hist_reg    <= '0;
      fill_reg    <= '0;
    end else begin
      if (cfg_take) begin
        pattern_reg <= cfg_pattern;
        len_reg     <= len_clamped;
        overlap_reg <= cfg_overlap;
        target_reg  <= cfg_target;
      end
      case (state_reg)
        IDLE: if (cfg_take) state_reg <= ARMED;
        ARMED: begin
          if (start) begin
            state_reg <= HUNT;
            count_reg <= '0;
            hist_reg  <= '0;
            fill_reg  <= '0;
          end
        end
        HUNT: begin
          if (stop) begin
            // Abort wins over a same-cycle match: z still fires, count does not move.
            state_reg <= ARMED;
          end else if (x_valid) begin
            hist_reg <= window[PAT_W-2:0];
            if (hit) begin
              count_reg <= count_inc;
              if (!overlap_reg)
                fill_reg <= '0;
              else if (!fill_full)
                fill_reg <= fill_reg + LEN_W'(1);
              if (target_reg != '0 && count_inc == target_reg)
                state_reg <= DONE;
            end else if (!fill_full) begin
              fill_reg <= fill_reg + LEN_W'(1);
            end
          end
        end
        DONE:    state_reg <= ARMED;
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef SEQ_DETECT_REG_OUT_EN
  logic z_reg;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) z_reg <= 1'b0;
    else        z_reg <= hit;
  end
  assign z = z_reg;
`else
  assign z = hit;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed literal scenarios plus randomized traffic
// compared each cycle against a queue-based behavioural model.
module tb_seq_detect_ctrl;
  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 8;
  localparam int M_IDLE = 0, M_ARMED = 1, M_HUNT = 2, M_DONE = 3;

  logic clk = 1'b0, reset = 1'b0;
  logic cfg_valid = 0, cfg_ready, cfg_overlap = 0, start = 0, stop = 0, x = 0, x_valid = 0;
  logic z, busy, done;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [CNT_W-1:0] cfg_target = '0, match_count;

  seq_detect_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_target(cfg_target), .start(start), .stop(stop), .x(x), .x_valid(x_valid),
    .z(z), .busy(busy), .done(done), .match_count(match_count));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  // Behavioural model: mode, stored config, match count, and the fresh bits seen so far.
  int   m_mode, m_len, m_tgt, m_cnt;
  logic [PAT_W-1:0] m_pat;
  bit   m_ovl;
  bit   bits[$];
  bit   ez_reg;
  logic s_z, s_busy, s_ready, s_done;
  int   s_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_len = 1; m_tgt = 0; m_cnt = 0; m_pat = '0; m_ovl = 0;
    bits.delete(); ez_reg = 0;
  endtask

  // The current bit plus the most recent len-1 fresh bits must spell the pattern, MSB first.
  function automatic bit tail_match(input bit xx);
    if (bits.size() + 1 < m_len) return 0;
    for (int k = 0; k < m_len; k++) begin
      bit b;
      b = (k == 0) ? xx : bits[bits.size() - k];
      if (b != m_pat[k]) return 0;
    end
    return 1;
  endfunction

  function automatic void model_load();
    m_pat = cfg_pattern;
    m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len));
    m_ovl = cfg_overlap;
    m_tgt = int'(cfg_target);
  endfunction

  function automatic void push_bit(input bit b);
    bits.push_back(b);
    if (bits.size() > PAT_W) void'(bits.pop_front());
  endfunction

  // One clock: check DUT against the model before the edge, then advance the model.
  task automatic tick();
    bit ez_comb, ez, hit;
    #1;
    ez_comb = (m_mode == M_HUNT) && x_valid && tail_match(x);
`ifdef SEQ_DETECT_REG_OUT_EN
    ez = ez_reg;
`else
    ez = ez_comb;
`endif
    chk("z", z, ez);
    chk("cfg_ready", cfg_ready, (m_mode == M_IDLE || m_mode == M_ARMED));
    chk("busy", busy, m_mode == M_HUNT);
    chk("done", done, m_mode == M_DONE);
    chk("match_count", match_count, m_cnt);
    s_z = z; s_busy = busy; s_ready = cfg_ready; s_done = done; s_cnt = match_count;
    @(posedge clk);
    ez_reg = ez_comb;
    case (m_mode)
      M_IDLE: if (cfg_valid) begin model_load(); m_mode = M_ARMED; end
      M_ARMED: begin
        if (cfg_valid) model_load();
        if (start) begin m_mode = M_HUNT; m_cnt = 0; bits.delete(); end
      end
      M_HUNT: begin
        if (stop) m_mode = M_ARMED;
        else if (x_valid) begin
          hit = tail_match(x);
          if (hit) begin
            m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
            if (m_ovl) push_bit(x); else bits.delete();
            if (m_tgt != 0 && m_cnt == m_tgt) m_mode = M_DONE;
          end else push_bit(x);
        end
      end
      default: m_mode = M_ARMED;
    endcase
    @(negedge clk);
  endtask

  task automatic idle();
    cfg_valid = 0; start = 0; stop = 0; x = 0; x_valid = 0;
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input bit o, input logic [7:0] t);
    idle(); cfg_valid = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
    tick();
    $display("cfg pattern=%b len=%0d overlap=%0b target=%0d ready=%0b", p, l, o, t, s_ready);
  endtask

  task automatic go();
    idle(); start = 1; tick(); idle();
  endtask

  task automatic do_stop();
    idle(); stop = 1; tick(); idle();
  endtask

  task automatic stream(input logic [15:0] bv, input logic [15:0] ze, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      idle(); x = bv[n-1-i]; x_valid = 1; tick();
      $display("bit %0d x=%0b z=%0b count=%0d", i + 1, bv[n-1-i], s_z, s_cnt);
`ifndef SEQ_DETECT_REG_OUT_EN
      chk("lit_z", s_z, ze[n-1-i]);
`endif
      if (gaps && i != n - 1) begin
        idle(); x = 1; x_valid = 0; tick();
`ifndef SEQ_DETECT_REG_OUT_EN
        chk("lit_gap_z", s_z, 0);
`endif
      end
    end
    idle();
  endtask

  task automatic pulse_reset();
    #2 reset = 0;
    #1;
    chk("rst_z", z, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_count", match_count, 0); chk("rst_ready", cfg_ready, 1);
    model_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    idle();
    @(negedge clk); @(negedge clk);
    reset = 1;
    @(negedge clk);
    idle(); tick();
    chk("lit_reset_ready", s_ready, 1); chk("lit_reset_busy", s_busy, 0);
    chk("lit_reset_count", s_cnt, 0);

    // 1: overlapping 1011 in 1011011
    do_cfg(8'b1011, 4, 1, 0); go();
    stream(16'b1011011, 16'b0001001, 7, 0);
    tick(); chk("t1_count", s_cnt, 2); chk("t1_busy", s_busy, 1);
    do_stop();

    // 2: non-overlapping
    do_cfg(8'b1011, 4, 0, 0); go();
    stream(16'b1011011, 16'b0001000, 7, 0);
    tick(); chk("t2_count", s_cnt, 1);
    do_stop();

    // 3: target reached
    do_cfg(8'b1011, 4, 1, 2); go();
    stream(16'b1011011, 16'b0001001, 7, 0);
    tick(); chk("t3_done", s_done, 1); chk("t3_busy", s_busy, 0); chk("t3_count", s_cnt, 2);
    tick(); chk("t3_done_after", s_done, 0); chk("t3_ready", s_ready, 1); chk("t3_count_hold", s_cnt, 2);

    // 4: gaps between valid bits
    do_cfg(8'b1011, 4, 1, 0); go();
    stream(16'b1011, 16'b0001, 4, 1);
    tick(); chk("t4_count", s_cnt, 1);
    do_stop();

    // 5: async reset mid-hunt, then a lone bit after restart must not match
    do_cfg(8'b1011, 4, 1, 0); go();
    stream(16'b101, 16'b000, 3, 0);
    pulse_reset();
    do_cfg(8'b1011, 4, 1, 0); go();
    stream(16'b1, 16'b0, 1, 0);
    do_stop();

    // 6: config refused during hunt; start ignored in IDLE
    do_cfg(8'b1011, 4, 1, 0); go();
    idle(); cfg_valid = 1; cfg_pattern = 8'b1; cfg_len = 1; tick();
    chk("t6_ready_hunt", s_ready, 0);
    stream(16'b1011, 16'b0001, 4, 0);
    do_stop();
    pulse_reset();
    idle(); start = 1; tick(); idle(); tick();
    chk("t6_busy_idle_start", s_busy, 0);

    // Counter saturation with len=1 and length clamp (len=0 -> 1)
    do_cfg(8'b1, 0, 1, 0); go();
    for (int i = 0; i < 260; i++) begin idle(); x = 1; x_valid = 1; tick(); end
    idle(); tick(); chk("sat_count", s_cnt, 255);
    do_stop();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cfg_valid   = ($urandom % 4 == 0);
      cfg_pattern = PAT_W'($urandom);
      cfg_len     = ($urandom % 4 == 0) ? LEN_W'($urandom % 16) : LEN_W'(1 + $urandom % 3);
      cfg_overlap = $urandom % 2;
      cfg_target  = CNT_W'($urandom % 4);
      start       = ($urandom % 3 == 0);
      stop        = ($urandom % 40 == 0);
      x           = $urandom % 2;
      x_valid     = ($urandom % 4 != 0);
      tick();
      if (i % 997 == 500) begin idle(); pulse_reset(); end
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
